// File: rtl/cve2_ex_sequencer.sv
// Sequencer between ID and EX: drives mult/div enables and selects, owns the
// intermediate value registers and holds the EX result for writeback.
module cve2_ex_sequencer #(
    parameter int unsigned MaxCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [1:0]        issue_kind_i,
    input  logic              kill_i,
    output logic              mult_en_o,
    output logic              div_en_o,
    output logic              mult_sel_o,
    output logic              div_sel_o,
    output logic              alu_instr_first_cycle_o,
    input  logic              ex_valid_i,
    input  logic [31:0]       result_ex_i,
    input  logic [1:0]        imd_val_we_i,
    input  logic [1:0][33:0]  imd_val_d_i,
    output logic [1:0][33:0]  imd_val_q_o,
    output logic              result_valid_o,
    output logic [31:0]       result_o,
    input  logic              result_ready_i,
    output logic              busy_o,
    output logic              err_timeout_o
);

    localparam int unsigned CNT_W = $clog2(MaxCycles);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MaxCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dec_kind;
    logic             dec_active;
    logic             imd_en;
    logic             res_we;
    logic [1:0][33:0] imd_q;
    logic [31:0]      result_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        kind_d                  = kind_q;
        cnt_d                   = cnt_q;
        dec_kind                = kind_q;
        dec_active              = 1'b0;
        imd_en                  = 1'b0;
        res_we                  = 1'b0;
        issue_ready_o           = 1'b0;
        alu_instr_first_cycle_o = 1'b0;
        err_timeout_o           = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue_ready_o = ~kill_i;
                if (issue_valid_i && !kill_i) begin
                    // Accept cycle doubles as EX cycle 1, decoded straight from ID.
                    dec_kind                = issue_kind_i;
                    dec_active              = 1'b1;
                    imd_en                  = 1'b1;
                    alu_instr_first_cycle_o = 1'b1;
                    if (ex_valid_i) begin
                        res_we  = 1'b1;
                        state_d = DONE;
                    end else begin
                        kind_d  = issue_kind_i;
                        cnt_d   = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    dec_active = 1'b1;
                    imd_en     = 1'b1;
                    if (ex_valid_i) begin
                        res_we  = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_timeout_o = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (kill_i || result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Kind 2'b11 is treated as ALU, so it raises neither enable nor select.
    assign mult_en_o  = dec_active && (dec_kind == 2'b01);
    assign mult_sel_o = dec_active && (dec_kind == 2'b01);
    assign div_en_o   = dec_active && (dec_kind == 2'b10);
    assign div_sel_o  = dec_active && (dec_kind == 2'b10);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imd_q    <= '0;
            result_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (imd_en && imd_val_we_i[k]) begin
                    imd_q[k] <= imd_val_d_i[k];
                end
            end
            if (res_we) begin
                result_q <= result_ex_i;
            end
        end
    end

    assign imd_val_q_o    = imd_q;
    assign result_o       = result_q;
    assign result_valid_o = (state_q == DONE);
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_cve2_ex_sequencer.sv
// Directed bench for cve2_ex_sequencer: a default instance plus a MaxCycles=8
// instance sharing the same stimulus for the watchdog case.
module tb_cve2_ex_sequencer;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [1:0]       issue_kind;
    logic             kill;
    logic             ex_valid;
    logic [31:0]      result_ex;
    logic [1:0]       imd_we;
    logic [1:0][33:0] imd_d;
    logic             result_ready;

    logic             issue_ready, mult_en, div_en, mult_sel, div_sel, alu_first;
    logic [1:0][33:0] imd_q;
    logic             result_valid, busy, err_timeout;
    logic [31:0]      result;

    logic             t_issue_ready, t_mult_en, t_div_en, t_mult_sel, t_div_sel, t_alu_first;
    logic [1:0][33:0] t_imd_q;
    logic             t_result_valid, t_busy, t_err_timeout;
    logic [31:0]      t_result;

    int checks = 0;
    int failures = 0;
    int n_en;
    int n_bad;
    int n_err;

    always #5 clk = ~clk;

    cve2_ex_sequencer dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_kind_i(issue_kind), .kill_i(kill), .mult_en_o(mult_en), .div_en_o(div_en),
        .mult_sel_o(mult_sel), .div_sel_o(div_sel), .alu_instr_first_cycle_o(alu_first),
        .ex_valid_i(ex_valid), .result_ex_i(result_ex), .imd_val_we_i(imd_we),
        .imd_val_d_i(imd_d), .imd_val_q_o(imd_q), .result_valid_o(result_valid),
        .result_o(result), .result_ready_i(result_ready), .busy_o(busy),
        .err_timeout_o(err_timeout)
    );

    cve2_ex_sequencer #(.MaxCycles(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(t_issue_ready),
        .issue_kind_i(issue_kind), .kill_i(kill), .mult_en_o(t_mult_en), .div_en_o(t_div_en),
        .mult_sel_o(t_mult_sel), .div_sel_o(t_div_sel), .alu_instr_first_cycle_o(t_alu_first),
        .ex_valid_i(ex_valid), .result_ex_i(result_ex), .imd_val_we_i(imd_we),
        .imd_val_d_i(imd_d), .imd_val_q_o(t_imd_q), .result_valid_o(t_result_valid),
        .result_o(t_result), .result_ready_i(result_ready), .busy_o(t_busy),
        .err_timeout_o(t_err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_kind   = 2'b00;
        kill         = 1'b0;
        ex_valid     = 1'b0;
        result_ex    = 32'h0;
        imd_we       = 2'b00;
        imd_d        = '0;
        result_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_imd0", 64'(imd_q[0]), 64'd0);
        chk("rst_imd1", 64'(imd_q[1]), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;

        // ALU single-cycle operation
        issue_valid = 1'b1; issue_kind = 2'b00; ex_valid = 1'b1; result_ex = 32'h0000_1234;
        #1;
        chk("alu_first", 64'(alu_first), 64'd1);
        chk("alu_issue_ready", 64'(issue_ready), 64'd1);
        chk("alu_mult_en", 64'(mult_en), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("alu_result_valid", 64'(result_valid), 64'd1);
        chk("alu_result", 64'(result), 64'h1234);
        chk("alu_busy", 64'(busy), 64'd1);
        chk("alu_done_ready", 64'(issue_ready), 64'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        #1;
        chk("alu_back_idle_ready", 64'(issue_ready), 64'd1);
        chk("alu_back_idle_valid", 64'(result_valid), 64'd0);

        // Reserved kind behaves as ALU: no enables or selects
        issue_valid = 1'b1; issue_kind = 2'b11; ex_valid = 1'b1; result_ex = 32'hA5A5_0011;
        #1;
        chk("k3_enables", 64'({mult_en, mult_sel, div_en, div_sel}), 64'd0);
        chk("k3_first", 64'(alu_first), 64'd1);
        tick();
        idle_inputs();
        result_ready = 1'b1;
        #1;
        chk("k3_result", 64'(result), 64'hA5A5_0011);
        tick();
        result_ready = 1'b0;

        // DIV lasting 37 EX cycles with intermediate writes every cycle
        n_en = 0; n_bad = 0;
        for (int i = 1; i <= 37; i++) begin
            issue_valid = (i == 1);
            issue_kind  = 2'b10;
            ex_valid    = (i == 37);
            result_ex   = 32'hFFFF_FFFF;
            imd_we      = 2'b11;
            imd_d[0]    = 34'(i);
            imd_d[1]    = 34'h3_0000_0000 | 34'(i);
            #1;
            if (div_en && div_sel) n_en++;
            tick();
            if (imd_q[0] !== 34'(i) || imd_q[1] !== (34'h3_0000_0000 | 34'(i))) n_bad++;
        end
        idle_inputs();
        #1;
        chk("div_en_cycles", 64'(n_en), 64'd37);
        chk("div_imd_track_errors", 64'(n_bad), 64'd0);
        chk("div_done_en", 64'({div_en, div_sel}), 64'd0);
        chk("div_result_valid", 64'(result_valid), 64'd1);
        chk("div_result", 64'(result), 64'hFFFF_FFFF);

        // Writeback backpressure: DONE held for 5 cycles, new issue refused
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1; issue_kind = 2'b01; result_ready = 1'b0;
            #1;
            chk("bp_result_valid", 64'(result_valid), 64'd1);
            chk("bp_result", 64'(result), 64'hFFFF_FFFF);
            chk("bp_issue_ready", 64'(issue_ready), 64'd0);
            chk("bp_mult_en", 64'(mult_en), 64'd0);
            tick();
        end
        issue_valid = 1'b0; result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        #1;
        chk("bp_release_idle", 64'(busy), 64'd0);

        // MUL killed in EX cycle 10, colliding with ex_valid
        n_en = 0;
        for (int i = 1; i <= 10; i++) begin
            issue_valid = (i == 1);
            issue_kind  = 2'b01;
            imd_we      = 2'b01;
            imd_d[0]    = 34'h2_0000_0000 | 34'(i);
            imd_d[1]    = 34'h0;
            kill        = (i == 10);
            ex_valid    = (i == 10);
            result_ex   = 32'h0000_DEAD;
            #1;
            if (i < 10) begin
                if (mult_en && mult_sel) n_en++;
            end else begin
                chk("kill_mult_en", 64'({mult_en, mult_sel}), 64'd0);
                chk("kill_first", 64'(alu_first), 64'd0);
                chk("kill_issue_ready", 64'(issue_ready), 64'd0);
            end
            tick();
        end
        idle_inputs();
        #1;
        chk("mul_en_cycles", 64'(n_en), 64'd9);
        chk("kill_imd0_unchanged", 64'(imd_q[0]), 64'h2_0000_0009);
        chk("kill_imd1_retained", 64'(imd_q[1]), 64'h3_0000_0025);
        chk("kill_idle", 64'(busy), 64'd0);
        chk("kill_no_result_valid", 64'(result_valid), 64'd0);
        chk("kill_result_kept", 64'(result), 64'hFFFF_FFFF);

        // Watchdog on the MaxCycles=8 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue_valid = 1'b1; issue_kind = 2'b01;
        tick();
        issue_valid = 1'b0;
        n_err = 0;
        for (int e = 1; e <= 8; e++) begin
            #1;
            if (e < 8) begin
                chk("to_mult_en", 64'(t_mult_en), 64'd1);
                if (t_err_timeout) n_err++;
            end else begin
                chk("to_err_pulse", 64'(t_err_timeout), 64'd1);
            end
            chk("to_no_valid", 64'(t_result_valid), 64'd0);
            tick();
        end
        #1;
        chk("to_early_pulses", 64'(n_err), 64'd0);
        chk("to_idle", 64'(t_busy), 64'd0);
        chk("to_err_dropped", 64'(t_err_timeout), 64'd0);
        chk("to_result_valid", 64'(t_result_valid), 64'd0);

        // Asynchronous reset while the default instance is still in EXEC
        imd_we = 2'b11; imd_d[0] = 34'h1_2345_6789; imd_d[1] = 34'h0_0000_00AB;
        tick();
        imd_we = 2'b00;
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_mult_en", 64'(mult_en), 64'd1);
        chk("pre_rst_imd0", 64'(imd_q[0]), 64'h1_2345_6789);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_mult_en", 64'(mult_en), 64'd0);
        chk("arst_imd0", 64'(imd_q[0]), 64'd0);
        chk("arst_imd1", 64'(imd_q[1]), 64'd0);
        chk("arst_result", 64'(result), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cve2_ex_sequencer.md
Name: cve2_ex_sequencer

Overview:
Sequencing controller sitting between ID and the execute stage (ALU + mult/div unit). It accepts one issued instruction at a time and drives the dynamic enables (mult_en/div_en), the static selects (mult_sel/div_sel) and alu_instr_first_cycle. It owns the intermediate value registers (imd_val), captures the EX result on ex_valid, and holds it for writeback under a valid/ready handshake. It also handles kill (flush) and a watchdog timeout for multi-cycle operations.

Parameters:
MaxCycles, 64, maximum cycles an operation may spend in EXEC before timeout; must be >= 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  ID presents an instruction
issue_ready_o  out  1  sequencer accepts the instruction
issue_kind_i  in  2  00 ALU, 01 MUL, 10 DIV, 11 reserved (treated as ALU)
kill_i  in  1  flush of the current operation
mult_en_o  out  1  dynamic multiplier enable to EX
div_en_o  out  1  dynamic divider enable to EX
mult_sel_o  out  1  static multiplier select to EX
div_sel_o  out  1  static divider select to EX
alu_instr_first_cycle_o  out  1  first cycle of an ALU operation
ex_valid_i  in  1  EX output valid
result_ex_i  in  32  EX result
imd_val_we_i  in  2  intermediate register write enables from EX
imd_val_d_i  in  2x34  intermediate register write data from EX
imd_val_q_o  out  2x34  intermediate register contents to EX
result_valid_o  out  1  captured result available
result_o  out  32  captured result
result_ready_i  in  1  writeback consumes the result
busy_o  out  1  state != IDLE
err_timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: state = IDLE. The following are all 0: imd_val_q, result_o, latched kind, cycle counter, err_timeout_o.
- States and transitions:
  - IDLE:
    - issue_ready_o = ~kill_i.
    - Accept = issue_valid_i & issue_ready_o. The accept cycle is EX cycle 1.
    - In the accept cycle, the enables/selects are decoded combinationally from issue_kind_i, and alu_instr_first_cycle_o = accept.
    - Accept & ex_valid_i: capture result_ex_i, go to DONE (single-cycle op; result_valid_o is asserted the following cycle).
    - Accept & ~ex_valid_i: latch the kind, clear the counter, go to EXEC.
  - EXEC:
    - mult_en/mult_sel (MUL) or div_en/div_sel (DIV) asserted from the latched kind. alu_instr_first_cycle_o = 0.
    - Counter increments each cycle.
    - ex_valid_i: capture result_ex_i, go to DONE.
    - Counter == MaxCycles-1 & ~ex_valid_i: pulse err_timeout_o, go to IDLE, no result.
  - DONE:
    - result_valid_o = 1. All enables and selects are 0. issue_ready_o = 0.
    - result_ready_i: go to IDLE.
    - result_o stays stable while result_valid_o & ~result_ready_i.
- Output decode:
  - mult_en_o/mult_sel_o = kind==01 and div_en_o/div_sel_o = kind==10, only in the accept cycle or in EXEC.
  - Kind 11 drives no enables or selects.
- Intermediate value registers:
  - imd_val_q[k] <= imd_val_d_i[k] when imd_val_we_i[k] is set, the state is accept-cycle or EXEC, and ~kill_i.
  - Writes in other states are ignored.
  - Contents are retained across operations (not cleared on accept).
- kill_i (highest priority, any state):
  - Same cycle: all enables, selects and alu_instr_first_cycle_o are forced to 0, issue_ready_o = 0, and no imd or result write.
  - Next state = IDLE; result_valid_o drops the next cycle.
  - kill_i beats ex_valid_i and timeout in the same cycle; err_timeout_o is not pulsed.
- Counter: width $clog2(MaxCycles). It never wraps because timeout exits EXEC first.
- Reset mid-operation: rst_i forces IDLE immediately (asynchronous); all outputs take their reset values.

Test Plan:
- ALU single-cycle: kind=00, ex_valid_i=1 in the accept cycle, result_ex_i=0x0000_1234 -> alu_instr_first_cycle_o=1 that cycle; next cycle result_valid_o=1, result_o=0x1234, busy_o=1; result_ready_i=1 -> IDLE, issue_ready_o=1 the cycle after.
- DIV 37 cycles: kind=10, ex_valid_i raised in EX cycle 37 with 0xFFFF_FFFF and imd_val_we_i=2'b11 each cycle -> div_en_o=div_sel_o=1 for exactly 37 cycles; imd_val_q_o tracks imd_val_d_i; result_o=0xFFFF_FFFF.
- Writeback backpressure: result_ready_i low for 5 cycles in DONE -> result_valid_o and result_o held; issue_valid_i ignored (issue_ready_o=0).
- Kill: kill_i in EX cycle 10 of a MUL with imd_val_we_i=2'b01 -> mult_en_o=0 that cycle; imd_val_q[0] unchanged; IDLE next cycle; no result_valid_o.
- Timeout: MaxCycles=8, MUL, ex_valid_i never asserted -> err_timeout_o pulses once in the 8th EXEC cycle; IDLE next cycle; result_valid_o stays 0.
- Async reset: assert rst_i mid-EXEC between clock edges -> busy_o, mult_en_o and imd_val_q_o go to 0 without waiting for a clock edge.
